// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared fetch-stage state encoding, instruction width and decoder opcodes.
package mips_fetch_pkg;
    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

`ifdef MIPS_FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_ERR} fetch_state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} fetch_state_t;
`endif
endpackage

// File: rtl/mips_fetch_stage_next_pc.sv
// mips_next_pc: combinational next-PC select (jump > taken branch > sequential).
module mips_next_pc
    import mips_fetch_pkg::*;
(
    input  logic [31:0]        pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    output logic [31:0]        next_pc
);
    logic [31:0] pc_plus4;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        next_pc  = jump            ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                   (branch & zero) ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
                                     pc_plus4;
    end
endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: PC register and req/ack instruction fetch feeding the MIPS decoders.
// Optional ack timeout with sticky error state when MIPS_FETCH_TIMEOUT_EN is defined.
module mips_fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic [31:0]        pc,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    output logic               fetch_err
);
    fetch_state_t state, state_d;
    logic [31:0]  next_pc;

    if (RESET_PC[1:0] != 2'b00 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mips_fetch_stage: RESET_PC must be word-aligned and TIMEOUT_CYCLES >= 1");
    end

    mips_next_pc u_next_pc (
        .pc      (pc),
        .instr   (instr),
        .branch  (branch),
        .jump    (jump),
        .zero    (zero),
        .next_pc (next_pc)
    );

`ifdef MIPS_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    assign timeout = wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            wait_cnt <= '0;
        else
            wait_cnt <= (state == S_FETCH && !imem_ack) ? wait_cnt + 1'b1 : '0;

    assign fetch_err = state == S_ERR;
`else
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = S_FETCH;
`ifdef MIPS_FETCH_TIMEOUT_EN
            S_FETCH: state_d = imem_ack ? S_HOLD : timeout ? S_ERR : S_FETCH;
`else
            S_FETCH: state_d = imem_ack ? S_HOLD : S_FETCH;
`endif
            S_HOLD:  state_d = instr_ready ? S_FETCH : S_HOLD;
            default: state_d = state;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_d;
            if (state == S_FETCH && imem_ack)
                instr <= imem_rdata;
            if (state == S_HOLD && instr_ready)
                pc <= next_pc;
        end

    assign imem_req    = state == S_FETCH;
    assign imem_addr   = pc;
    assign instr_valid = state == S_HOLD;
    assign op          = instr[31:26];
    assign funct       = instr[5:0];
endmodule
